gate_pair_checker: RTL

Self-running truth-table sequencer and comparator for two-input-class gate experiments. It drives every input vector onto a device under test and a reference implementation, for example a NAND-built gate against its behavioural equivalent. After a settle interval it compares the two outputs, then reports a mismatch count and the first failing vector. It replaces hand-written `#1` stimulus lists in the gate-chapter benches with a clocked, reusable driver/checker.

---
 rtl/gate_pair_checker_pkg.sv | 21 ++
 rtl/gate_pair_checker_if.sv | 11 +
 rtl/gate_pair_checker.sv | 100 ++++++++++
 3 files changed

// File: rtl/gate_pair_checker_pkg.sv
// Shared types and defaults for the gate pair truth-table sequencer/checker.
package gate_pair_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_N      = 2;
  localparam int DEF_SETTLE = 1;

  // Settle counter must hold SETTLE itself; never narrower than one bit.
  function automatic int settle_cnt_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gate_pair_checker_if.sv
// Bus between the checker and the gate pair: driven vector out, two gate outputs back.
interface gate_pair_checker_if #(
  parameter int N = 2
);
  logic [N-1:0] x;
  logic         r_ref;
  logic         r_dut;

  modport master (output x, input r_ref, input r_dut);
  modport slave  (input x, output r_ref, output r_dut);
endinterface

// File: rtl/gate_pair_checker.sv
// Sweeps every N-bit vector onto a gate pair, compares the two outputs after a
// settle interval, and reports the mismatch count and the lowest failing vector.
module gate_pair_checker
  import gate_pair_checker_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  gate_pair_checker_if.master  pair,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N:0]           mism_cnt,
  output logic                 fail_vld,
  output logic [N-1:0]         first_fail,
  output state_t               state_dbg
);

  localparam int             CW       = settle_cnt_width(SETTLE);
  localparam logic [CW-1:0]  SETTLE_V = CW'(SETTLE);
  localparam logic [N-1:0]   X_LAST   = {N{1'b1}};

  // Handshake: start is a level sampled only in IDLE or DONE; busy is high for
  // the whole sweep; done is a sticky level held until the next accepted start.

  state_t        state;
  logic [N-1:0]  vec;
  logic [CW-1:0] settle_cnt;
  logic          mis;
  logic [N:0]    cnt_nx;

  // Case matching routes an unknown xor result into the mismatch branch.
  always_comb begin
    mis = 1'b1;
    case (pair.r_ref ^ pair.r_dut)
      1'b0:    mis = 1'b0;
      default: mis = 1'b1;
    endcase
  end

  assign cnt_nx    = mism_cnt + (N+1)'(mis);
  assign pair.x    = vec;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mism_cnt   <= '0;
      fail_vld   <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec        <= '0;
            mism_cnt   <= '0;
            fail_vld   <= 1'b0;
            first_fail <= '0;
            settle_cnt <= SETTLE_V;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt == CW'(1)) state <= ST_CMP;
        end
        ST_CMP: begin
          mism_cnt <= cnt_nx;
          if (mis && !fail_vld) begin
            first_fail <= vec;
            fail_vld   <= 1'b1;
          end
          if (vec == X_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_nx == '0);
            state <= ST_DONE;
          end else begin
            vec        <= vec + N'(1);
            settle_cnt <= SETTLE_V;
            state      <= ST_HOLD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
